axi4_lite_slave_regbank: RTL and testbench
==========================================

AXI4_LITE_SLAVE_REGBANK -- requirements
Module: axi4_lite_slave_regbank

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, 9, byte-address width.
REQ-002 Parameter AXI_DATA_WIDTH, 32, data width (only 32 supported).
REQ-003 Parameter NUM_REGS, 16, register count (4..128); index NUM_REGS-2 = IRQ_MASK, NUM_REGS-1 = IRQ_STATUS.
REQ-004 ACLK  in  1  clock; ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 S_AXI_awaddr  in  AXI_ADDR_WIDTH  write address; S_AXI_awvalid in 1; S_AXI_awready out 1.
REQ-006 S_AXI_wdata  in  32  write data; S_AXI_wstrb in 4 byte enables; S_AXI_wvalid in 1; S_AXI_wready out 1.
REQ-007 S_AXI_bresp  out  2  write response; S_AXI_bvalid out 1; S_AXI_bready in 1.
REQ-008 S_AXI_araddr  in  AXI_ADDR_WIDTH  read address; S_AXI_arvalid in 1; S_AXI_arready out 1.
REQ-009 S_AXI_rdata  out  32; S_AXI_rresp out 2; S_AXI_rvalid out 1; S_AXI_rready in 1.
REQ-010 ctrl_out  out  32*(NUM_REGS-2)  flattened RW registers, index 0 at LSBs.
REQ-011 event_in  in  32  hardware event lines, synchronous to ACLK.
REQ-012 irq_n  out  1  active-low interrupt, registered.

Function
REQ-013 Word index = addr[AXI_ADDR_WIDTH-1:2]; addr[1:0] SHALL be ignored.
REQ-014 Write channel: AW and W accepted independently; awready high when no AW latched and bvalid low; wready same for W.
REQ-015 Write commit SHALL occur the cycle after both AW and W are latched; bvalid asserts same cycle as commit, held with stable bresp until bready.
REQ-016 AW and W handshaking in the same cycle SHALL commit the next cycle (1-cycle latency to bvalid).
REQ-017 RW registers: byte lane n written only where wstrb[n]=1.
REQ-018 IRQ_STATUS: bit set on rising edge of event_in bit (edge vs. registered previous value); write-1-to-clear, byte-masked by wstrb; set beats clear same cycle.
REQ-019 Index >= NUM_REGS: no state change, bresp/rresp = 2'b10 (SLVERR), rdata = 0; otherwise OKAY 2'b00.
REQ-020 Read FSM states R_IDLE, R_DATA: arready=1 only in R_IDLE; AR handshake -> R_DATA with rdata captured that edge; rvalid=1 in R_DATA; rvalid&rready -> R_IDLE.
REQ-021 Read latency: rvalid the cycle after AR handshake; rdata/rresp stable while rvalid&!rready.
REQ-022 Read and write commit to same register same cycle: read returns pre-write value.
REQ-023 Read and write channels SHALL operate concurrently without interlock.
REQ-024 irq_n = ~|(IRQ_STATUS & IRQ_MASK), registered one cycle after status/mask change.
REQ-025 wstrb=4'b0000 write SHALL respond OKAY with no state change.

Reset
REQ-026 On ARESETN low: all registers, IRQ_STATUS, event history = 0; awready/wready/arready = 0 during reset, 1 first cycle after; bvalid/rvalid = 0; bresp/rresp/rdata = 0; irq_n = 1; read FSM R_IDLE.
REQ-027 Reset mid-transaction SHALL abort it immediately; no partial write persists beyond reset.

Structure
REQ-028 Shared package: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, read-FSM state encodings, IRQ_MASK/IRQ_STATUS index offsets.
REQ-029 One sub-module, axi4_lite_slave_rd_ch (read FSM + rdata capture); write path and register array stay in top.

Verification
REQ-030 AW+W same cycle to 0x004, wdata 0xDEADBEEF, wstrb 4'hF -> bvalid 1 cycle later, bresp 0, ctrl_out[63:32]=0xDEADBEEF.
REQ-031 W first, AW 3 cycles later to 0x000, wstrb 4'b0010, wdata 0x0000AB00 on 0 reg -> reg0=0x0000AB00; bready held low 5 cycles -> bvalid held, awready/wready 0.
REQ-032 Read 0x040 (index 16) -> rvalid next cycle, rresp 2'b10, rdata 0; write 0x1FC -> bresp 2'b10, no register changes.
REQ-033 IRQ_MASK=0x1, pulse event_in[0] -> IRQ_STATUS=0x1, irq_n low; write 0x1 to IRQ_STATUS concurrent with new event_in[0] edge -> bit stays set; clean W1C -> irq_n high.
REQ-034 Read with rready low 4 cycles while write changes same register -> rdata stable, old value.
REQ-035 Assert ARESETN low with bvalid and rvalid pending -> both drop asynchronously, all registers 0, irq_n 1.

Source files
------------

// File: rtl/axi4_lite_slave_regbank_pkg.sv
// rtl/axi4_lite_slave_regbank_pkg.sv - shared constants, types and helpers for the register bank
package axi4_lite_slave_regbank_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Interrupt registers sit at the top of the register map, counted back from NUM_REGS
    localparam int IRQ_MASK_OFS   = 2;
    localparam int IRQ_STATUS_OFS = 1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Expand byte enables into a per-bit write mask
    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_W; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_regbank_if.sv
// rtl/axi4_lite_slave_regbank_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi4_lite_slave_regbank_if #(
    parameter int AXI_ADDR_WIDTH = 9
);
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [31:0]               wdata;
    logic [3:0]                wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      arready;
    logic [31:0]               rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_slave_regbank_rd_ch.sv
// rtl/axi4_lite_slave_regbank_rd_ch.sv - read channel FSM with read data/response capture
module axi4_lite_slave_rd_ch
    import axi4_lite_slave_regbank_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              ready_en,
    input  logic              arvalid,
    output logic              arready,
    input  logic [DATA_W-1:0] rd_word,
    input  logic              rd_err,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    rd_state_t state_q;
    rd_state_t state_d;
    logic      ar_hs;

    assign ar_hs = (state_q == R_IDLE) && arvalid && ready_en;

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d = state_q;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            R_IDLE: begin
                arready = ready_en;
                if (arvalid && ready_en) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Capture data on the AR handshake edge so it holds steady until the master takes it
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= rd_word;
            rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regbank.sv
// rtl/axi4_lite_slave_regbank.sv - AXI4-Lite register bank with control registers and edge interrupts
module axi4_lite_slave_regbank
    import axi4_lite_slave_regbank_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 9,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 16
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    axi4_lite_slave_regbank_if.slave               S_AXI,
    output logic [AXI_DATA_WIDTH*(NUM_REGS-2)-1:0] ctrl_out,
    input  logic [AXI_DATA_WIDTH-1:0]              event_in,
    output logic                                   irq_n
);

    localparam int IDX_W      = AXI_ADDR_WIDTH - 2;
    localparam int NUM_RW     = NUM_REGS - 2;
    localparam int MASK_IDX   = NUM_REGS - IRQ_MASK_OFS;
    localparam int STATUS_IDX = NUM_REGS - IRQ_STATUS_OFS;

    logic [DATA_W-1:0] ctrl_regs [NUM_RW];
    logic [DATA_W-1:0] irq_mask_q;
    logic [DATA_W-1:0] irq_status_q;
    logic [DATA_W-1:0] event_q;
    logic [DATA_W-1:0] event_rise;
    logic [DATA_W-1:0] status_clr;

    logic              ready_en;
    logic              aw_full;
    logic              w_full;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic              wr_err;
    logic [DATA_W-1:0] wr_mask;

    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI.awaddr[1:0], S_AXI.araddr[1:0]};

    // Write channel: each half is accepted once, then blocked until the response is taken
    assign S_AXI.awready = ready_en & ~aw_full & ~bvalid_q;
    assign S_AXI.wready  = ready_en & ~w_full & ~bvalid_q;
    assign S_AXI.bvalid  = bvalid_q;
    assign S_AXI.bresp   = bresp_q;

    assign aw_hs   = S_AXI.awvalid & S_AXI.awready;
    assign w_hs    = S_AXI.wvalid & S_AXI.wready;
    assign commit  = aw_full & w_full;
    assign wr_err  = int'(aw_idx_q) >= NUM_REGS;
    assign wr_mask = strb_to_mask(wstrb_q);

    // Ready outputs stay low while reset is held and come up on the first clock afterwards
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Latch AW and W independently; commit and raise the response once both are held
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= S_AXI.awaddr[AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                wdata_q <= S_AXI.wdata;
                wstrb_q <= S_AXI.wstrb;
            end
            if (bvalid_q && S_AXI.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Byte-masked update of the control registers and the interrupt mask
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_RW; i++) begin
                ctrl_regs[i] <= '0;
            end
            irq_mask_q <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    ctrl_regs[i] <= (ctrl_regs[i] & ~wr_mask) | (wdata_q & wr_mask);
                end
            end
            if (aw_idx_q == IDX_W'(MASK_IDX)) begin
                irq_mask_q <= (irq_mask_q & ~wr_mask) | (wdata_q & wr_mask);
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_out[g*DATA_W +: DATA_W] = ctrl_regs[g];
    end

    // A new event edge wins over a simultaneous write-1-to-clear of the same bit
    assign event_rise = event_in & ~event_q;
    assign status_clr = (commit && aw_idx_q == IDX_W'(STATUS_IDX)) ? (wdata_q & wr_mask) : '0;

    // Event edge history, sticky status bits and the registered interrupt output
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            event_q      <= '0;
            irq_status_q <= '0;
            irq_n        <= 1'b1;
        end else begin
            event_q      <= event_in;
            irq_status_q <= (irq_status_q & ~status_clr) | event_rise;
            irq_n        <= ~|(irq_status_q & irq_mask_q);
        end
    end

    assign rd_idx = S_AXI.araddr[AXI_ADDR_WIDTH-1:2];

    // Read mux; the read channel samples it on the AR handshake, before any same-edge write lands
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (int'(rd_idx) >= NUM_REGS) begin
            rd_err = 1'b1;
        end else if (rd_idx == IDX_W'(MASK_IDX)) begin
            rd_word = irq_mask_q;
        end else if (rd_idx == IDX_W'(STATUS_IDX)) begin
            rd_word = irq_status_q;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_word = ctrl_regs[i];
                end
            end
        end
    end

    axi4_lite_slave_rd_ch u_rd_ch (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .ready_en (ready_en),
        .arvalid  (S_AXI.arvalid),
        .arready  (S_AXI.arready),
        .rd_word  (rd_word),
        .rd_err   (rd_err),
        .rdata    (S_AXI.rdata),
        .rresp    (S_AXI.rresp),
        .rvalid   (S_AXI.rvalid),
        .rready   (S_AXI.rready)
    );

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
// tb/tb_axi4_lite_slave_regbank.sv - self-checking scoreboard bench for the AXI4-Lite register bank
module tb_axi4_lite_slave_regbank;
    import axi4_lite_slave_regbank_pkg::*;

    localparam int NR  = 16;
    localparam int NRW = NR - 2;

    logic                ACLK = 1'b0;
    logic                ARESETN = 1'b0;
    logic [32*NRW-1:0]   ctrl_out;
    logic [31:0]         event_in;
    logic                irq_n;

    axi4_lite_slave_regbank_if #(.AXI_ADDR_WIDTH(9)) bus ();

    axi4_lite_slave_regbank #(
        .AXI_ADDR_WIDTH (9),
        .AXI_DATA_WIDTH (32),
        .NUM_REGS       (NR)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .S_AXI    (bus),
        .ctrl_out (ctrl_out),
        .event_in (event_in),
        .irq_n    (irq_n)
    );

    always #5 ACLK = ~ACLK;

    int          n_chk;
    int          n_pass;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [31:0] m_regs [NRW];
    logic [31:0] m_mask;
    logic [31:0] m_status;
    logic [1:0]  exp_b;
    logic [33:0] exp_r;
    int          lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] model_read(input logic [8:0] a);
        int idx;
        idx = int'(a[8:2]);
        if (idx >= NR)     return {2'b10, 32'h0};
        if (idx == NR - 2) return {2'b00, m_mask};
        if (idx == NR - 1) return {2'b00, m_status};
        return {2'b00, m_regs[idx]};
    endfunction

    task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        int          idx;
        logic [31:0] m;
        idx = int'(a[8:2]);
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
        if (idx < NRW)          m_regs[idx] = (m_regs[idx] & ~m) | (d & m);
        else if (idx == NR - 2) m_mask      = (m_mask & ~m) | (d & m);
        else if (idx == NR - 1) m_status    = m_status & ~(d & m);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NRW; i++) m_regs[i] = 32'h0;
        m_mask   = 32'h0;
        m_status = 32'h0;
    endtask

    task automatic chk_all_ctrl(input string tag);
        for (int i = 0; i < NRW; i++) chk(tag, ctrl_out[i*32 +: 32], m_regs[i]);
    endtask

    // W is offered first; AW follows aw_delay cycles later. bready is held low for b_hold cycles.
    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_delay, input int b_hold, output int b_lat);
        logic aw_fire, w_fire, aw_done, w_done;
        int   cyc;
        bq.push_back((int'(a[8:2]) >= NR) ? 2'b10 : 2'b00);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.wvalid  = 1'b1;
        bus.awvalid = (aw_delay == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge ACLK);
            aw_fire = bus.awvalid & bus.awready;
            w_fire  = bus.wvalid & bus.wready;
            if (w_done && !aw_done) chk("wready_blocked", bus.wready, 0);
            @(posedge ACLK); #1;
            cyc++;
            if (aw_fire) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
            if (!aw_done && cyc >= aw_delay) bus.awvalid = 1'b1;
        end
        chk("w_handshake", aw_done && w_done, 1);
        b_lat = 0;
        @(negedge ACLK);
        while (!bus.bvalid && b_lat < 20) begin
            @(negedge ACLK);
            b_lat++;
        end
        for (int i = 0; i < b_hold; i++) begin
            chk("bvalid_hold", bus.bvalid, 1);
            chk("awready_hold", bus.awready, 0);
            chk("wready_hold", bus.wready, 0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1 bus.bready = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1 bus.bready = 1'b0;
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [8:0] a, input int r_hold);
        logic [33:0] e;
        logic        fire;
        int          cyc;
        e = model_read(a);
        rq.push_back(e);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        fire = 1'b0;
        cyc  = 0;
        while (!fire && cyc < 50) begin
            @(negedge ACLK);
            fire = bus.arready;
            @(posedge ACLK); #1;
            cyc++;
        end
        bus.arvalid = 1'b0;
        chk("ar_handshake", fire, 1);
        @(negedge ACLK);
        chk("r_latency", bus.rvalid, 1);
        for (int i = 0; i < r_hold; i++) begin
            chk("rdata_hold", bus.rdata, e[31:0]);
            @(negedge ACLK);
            chk("rvalid_hold", bus.rvalid, 1);
        end
        @(posedge ACLK); #1 bus.rready = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1 bus.rready = 1'b0;
    endtask

    task automatic pulse_event0();
        @(posedge ACLK); #1 event_in[0] = 1'b1;
        @(posedge ACLK); #1 event_in[0] = 1'b0;
        m_status = m_status | 32'h1;
    endtask

    // Scoreboard: pop and compare whenever the DUT completes a response handshake
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                end else begin
                    exp_b = bq.pop_front();
                    chk("bresp", {30'b0, bus.bresp}, {30'b0, exp_b});
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    exp_r = rq.pop_front();
                    chk("rresp", {30'b0, bus.rresp}, {30'b0, exp_r[33:32]});
                    chk("rdata", bus.rdata, exp_r[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        model_reset();
        event_in    = 32'h0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_irq_n", irq_n, 1);
        chk_all_ctrl("rst_ctrl");
        @(posedge ACLK); #1 ARESETN = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("post_rst_awready", bus.awready, 1);
        chk("post_rst_wready", bus.wready, 1);
        chk("post_rst_arready", bus.arready, 1);
        @(posedge ACLK); #1;

        // Simultaneous AW/W, full word
        axi_write(9'h004, 32'hDEADBEEF, 4'hF, 0, 0, lat);
        chk("b_latency_same_cycle", lat, 1);
        chk("reg1_full", ctrl_out[63:32], 32'hDEADBEEF);
        axi_read(9'h004, 0);

        // W before AW, single byte lane, response back-pressured
        axi_write(9'h000, 32'h0000AB00, 4'b0010, 3, 5, lat);
        chk("b_latency_split", lat, 1);
        chk("reg0_byte1", ctrl_out[31:0], 32'h0000AB00);

        // Alternate byte lanes and an all-zero strobe
        axi_write(9'h008, 32'hFFFFFFFF, 4'b0101, 0, 0, lat);
        chk("reg2_lanes", ctrl_out[95:64], 32'h00FF00FF);
        axi_write(9'h00F, 32'h12345678, 4'b0000, 0, 0, lat);
        chk_all_ctrl("zero_strb");

        // Out-of-range accesses
        axi_read(9'h040, 0);
        axi_write(9'h1FC, 32'hFFFFFFFF, 4'hF, 0, 0, lat);
        chk_all_ctrl("oor_write");
        axi_read(9'h00A, 0);

        // Interrupt: mask, edge set, clear racing a new edge, clean clear
        axi_write(9'h038, 32'h1, 4'hF, 0, 0, lat);
        pulse_event0();
        @(posedge ACLK);
        @(negedge ACLK);
        chk("irq_n_asserted", irq_n, 0);
        @(posedge ACLK); #1;
        axi_read(9'h03C, 0);
        fork
            axi_write(9'h03C, 32'h1, 4'hF, 0, 0, lat);
            begin : edge_gen
                int k;
                k = 0;
                @(negedge ACLK);
                while ((bus.awready || bus.wready || bus.bvalid) && k < 20) begin
                    @(negedge ACLK);
                    k++;
                end
                event_in[0] = 1'b1;
                @(posedge ACLK); #1 event_in[0] = 1'b0;
            end
        join
        m_status = m_status | 32'h1;
        @(negedge ACLK);
        chk("irq_n_set_wins", irq_n, 0);
        @(posedge ACLK); #1;
        axi_read(9'h03C, 0);
        axi_write(9'h03C, 32'h1, 4'hF, 0, 0, lat);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("irq_n_cleared", irq_n, 1);
        @(posedge ACLK); #1;
        axi_read(9'h03C, 0);

        // Read held off while a write updates the same register
        fork
            axi_read(9'h004, 4);
            axi_write(9'h004, 32'hCAFEF00D, 4'hF, 0, 0, lat);
        join
        axi_read(9'h004, 0);

        // Reset with both responses outstanding
        pulse_event0();
        bus.awaddr  = 9'h010;
        bus.wdata   = 32'h55AA55AA;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 9'h004;
        bus.arvalid = 1'b1;
        @(posedge ACLK); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("pend_bvalid", bus.bvalid, 1);
        chk("pend_rvalid", bus.rvalid, 1);
        chk("pend_irq_n", irq_n, 0);
        chk("pend_reg4", ctrl_out[159:128], 32'h55AA55AA);
        #1 ARESETN = 1'b0;
        #1;
        model_reset();
        chk("arst_bvalid", bus.bvalid, 0);
        chk("arst_rvalid", bus.rvalid, 0);
        chk("arst_bresp", bus.bresp, 0);
        chk("arst_rdata", bus.rdata, 0);
        chk("arst_irq_n", irq_n, 1);
        chk("arst_awready", bus.awready, 0);
        chk_all_ctrl("arst_ctrl");
        @(posedge ACLK); #1 ARESETN = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("rearm_awready", bus.awready, 1);
        @(posedge ACLK); #1;
        axi_read(9'h038, 0);
        axi_read(9'h004, 0);

        repeat (3) @(posedge ACLK);
        chk("bq_drained", bq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
